// File: rtl/alu_arbiter.sv
// -----------------------------------------------------------------------------
// alu_arbiter
//
// Shares one ALU + register-file datapath between two requesters. One
// operation is issued per cycle under round-robin arbitration; a tag per
// issued operation travels alongside the fixed-latency datapath. When the tag
// emerges, the datapath result and flags are written into the response FIFO of
// the requester that issued it. Issue is credit based: a requester may only
// issue while (in-flight + queued responses) < RSP_DEPTH, so a returning
// result always finds a free FIFO slot.
//
// Parameters
//   n          operand / result width
//   LAT        clock edges from issue edge to the edge that samples alu_R0
//   RSP_DEPTH  response FIFO depth and per-requester outstanding limit
//
// Ports
//   clk, rst_n                     clock, asynchronous active-low reset
//   reqK_valid/ready/a/b/op        operation request from requester K
//   rspK_valid/ready/data/flags    response FIFO head for requester K,
//                                  flags = {overflow, zero, carry}
//   alu_R2, alu_R3, alu_op         registered operands / ALUOp to datapath
//   alu_R0, alu_overflow/zero/carry result and flags from datapath
//
// Handshake semantics (both request and response channels): a transfer happens
// on a rising clk edge where valid && ready are both high. reqK_ready is a
// pure function of reqK_valid and registered counters (never of rspK_ready),
// and is low whenever rst_n is low. rspK_valid is the FIFO non-empty flag; the
// head is popped on an edge where rspK_valid && rspK_ready.
// -----------------------------------------------------------------------------
module alu_arbiter #(
    parameter int n         = 32,
    parameter int LAT       = 2,
    parameter int RSP_DEPTH = 2
) (
    input  logic         clk,
    input  logic         rst_n,

    input  logic         req0_valid,
    output logic         req0_ready,
    input  logic [n-1:0] req0_a,
    input  logic [n-1:0] req0_b,
    input  logic [2:0]   req0_op,

    input  logic         req1_valid,
    output logic         req1_ready,
    input  logic [n-1:0] req1_a,
    input  logic [n-1:0] req1_b,
    input  logic [2:0]   req1_op,

    output logic         rsp0_valid,
    input  logic         rsp0_ready,
    output logic [n-1:0] rsp0_data,
    output logic [2:0]   rsp0_flags,

    output logic         rsp1_valid,
    input  logic         rsp1_ready,
    output logic [n-1:0] rsp1_data,
    output logic [2:0]   rsp1_flags,

    output logic [n-1:0] alu_R2,
    output logic [n-1:0] alu_R3,
    output logic [2:0]   alu_op,

    input  logic [n-1:0] alu_R0,
    input  logic         alu_overflow,
    input  logic         alu_zero,
    input  logic         alu_carry
);

    // Counter width holds 0..RSP_DEPTH; pointer width addresses the FIFO.
    localparam int CW = $clog2(RSP_DEPTH + 1);
    localparam int PW = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
    localparam int EW = n + 3;
    localparam logic [CW:0]   DEPTH_C = (CW + 1)'(RSP_DEPTH);
    localparam logic [PW-1:0] LAST_P  = PW'(RSP_DEPTH - 1);

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        if (p == LAST_P) begin
            return '0;
        end
        return p + 1'b1;
    endfunction

    // ---------------------------------------------------------------------
    // Arbitration
    // ---------------------------------------------------------------------
    logic [1:0] req_valid;
    logic [1:0] rsp_ready;
    logic [1:0] elig;
    logic [1:0] rsp_valid;
    logic       ptr;
    logic       gnt_valid;
    logic       gnt_id;
    logic       issue;

    assign req_valid = {req1_valid, req0_valid};
    assign rsp_ready = {rsp1_ready, rsp0_ready};

    always_comb begin
        gnt_valid = 1'b0;
        gnt_id    = 1'b0;
        if (elig[0] && elig[1]) begin
            gnt_valid = 1'b1;
            gnt_id    = ptr;
        end else if (elig[0]) begin
            gnt_valid = 1'b1;
            gnt_id    = 1'b0;
        end else if (elig[1]) begin
            gnt_valid = 1'b1;
            gnt_id    = 1'b1;
        end
    end

    // rst_n gating keeps ready low during reset even though the cleared
    // counters would otherwise make a valid requester eligible.
    assign issue      = gnt_valid && rst_n;
    assign req0_ready = issue && !gnt_id;
    assign req1_ready = issue && gnt_id;

    // Priority pointer moves to the loser after every grant, holds otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= 1'b0;
        end else if (issue) begin
            ptr <= ~gnt_id;
        end
    end

    // ---------------------------------------------------------------------
    // Operand registers towards the datapath (hold when nothing issues)
    // ---------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_R2 <= '0;
            alu_R3 <= '0;
            alu_op <= '0;
        end else if (issue) begin
            alu_R2 <= gnt_id ? req1_a  : req0_a;
            alu_R3 <= gnt_id ? req1_b  : req0_b;
            alu_op <= gnt_id ? req1_op : req0_op;
        end
    end

    // ---------------------------------------------------------------------
    // Tag pipeline: stage 0 loads at the issue edge, so the tag leaving
    // stage LAT-1 lines up with the edge at which alu_R0 is sampled.
    // ---------------------------------------------------------------------
    logic [LAT-1:0] tag_v;
    logic [LAT-1:0] tag_id;
    logic           ret_v;
    logic           ret_id;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tag_v  <= '0;
            tag_id <= '0;
        end else begin
            tag_v[0]  <= issue;
            tag_id[0] <= gnt_id;
            for (int i = 1; i < LAT; i++) begin
                tag_v[i]  <= tag_v[i-1];
                tag_id[i] <= tag_id[i-1];
            end
        end
    end

    assign ret_v  = tag_v[LAT-1];
    assign ret_id = tag_id[LAT-1];

    // ---------------------------------------------------------------------
    // Per-requester credit counters and response FIFO
    // ---------------------------------------------------------------------
    for (genvar k = 0; k < 2; k++) begin : gen_rsp
        logic [CW-1:0] inflight;
        logic [CW-1:0] occ;
        logic [PW-1:0] wr_ptr;
        logic [PW-1:0] rd_ptr;
        logic [EW-1:0] mem [RSP_DEPTH];
        logic          iss;
        logic          ret;
        logic          pop;
        logic [EW-1:0] head;

        assign iss = issue && (gnt_id == 1'(k));
        assign ret = ret_v && (ret_id == 1'(k));
        assign pop = rsp_valid[k] && rsp_ready[k];

        // Eligibility sees only registered counts, so a credit released by a
        // pop becomes usable one cycle later and rspK_ready never reaches
        // reqK_ready combinationally.
        assign elig[k] = req_valid[k] &&
                         (({1'b0, inflight} + {1'b0, occ}) < DEPTH_C);

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                inflight <= '0;
                occ      <= '0;
                wr_ptr   <= '0;
                rd_ptr   <= '0;
            end else begin
                if (iss && !ret) begin
                    inflight <= inflight + 1'b1;
                end else if (!iss && ret) begin
                    inflight <= inflight - 1'b1;
                end

                if (ret && !pop) begin
                    occ <= occ + 1'b1;
                end else if (!ret && pop) begin
                    occ <= occ - 1'b1;
                end

                if (ret) begin
                    wr_ptr <= ptr_inc(wr_ptr);
                end
                if (pop) begin
                    rd_ptr <= ptr_inc(rd_ptr);
                end
            end
        end

        // Storage needs no reset: occupancy alone decides what is visible.
        always_ff @(posedge clk) begin
            if (ret) begin
                mem[wr_ptr] <= {alu_overflow, alu_zero, alu_carry, alu_R0};
            end
        end

        assign rsp_valid[k] = (occ != '0);
        // Head is forced to zero when empty so stale entries never show,
        // including straight after a reset that interrupted traffic.
        assign head = rsp_valid[k] ? mem[rd_ptr] : '0;
    end

    assign rsp0_valid = rsp_valid[0];
    assign rsp1_valid = rsp_valid[1];
    assign rsp0_data  = gen_rsp[0].head[n-1:0];
    assign rsp0_flags = gen_rsp[0].head[EW-1:n];
    assign rsp1_data  = gen_rsp[1].head[n-1:0];
    assign rsp1_flags = gen_rsp[1].head[EW-1:n];

endmodule

// File: tb/tb_alu_arbiter.sv
// -----------------------------------------------------------------------------
// tb_alu_arbiter
//
// Drives both request channels and both response-ready inputs, stands in for
// the ALU datapath with a LAT-cycle behavioural model, and checks the arbiter
// against a transaction-level reference: per-requester outstanding counts
// (issued minus consumed) decide eligibility, a priority bit decides ties, and
// per-requester queues of expected {flags, data} with a visibility cycle decide
// what each response port must present.
// -----------------------------------------------------------------------------
module tb_alu_arbiter;
  localparam int N     = 32;
  localparam int LAT   = 2;
  localparam int DEPTH = 2;
  localparam int W     = N + 3;

  // ---------------------------------------------------------------------------
  // Clock / reset and DUT signals
  // ---------------------------------------------------------------------------
  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         req0_valid, req0_ready, req1_valid, req1_ready;
  logic [N-1:0] req0_a, req0_b, req1_a, req1_b;
  logic [2:0]   req0_op, req1_op;
  logic         rsp0_valid, rsp0_ready, rsp1_valid, rsp1_ready;
  logic [N-1:0] rsp0_data, rsp1_data;
  logic [2:0]   rsp0_flags, rsp1_flags;
  logic [N-1:0] alu_R2, alu_R3, alu_R0;
  logic [2:0]   alu_op;
  logic         alu_overflow, alu_zero, alu_carry;

  always #5 clk = ~clk;

  alu_arbiter #(.n(N), .LAT(LAT), .RSP_DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready),
    .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
    .req1_valid(req1_valid), .req1_ready(req1_ready),
    .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready),
    .rsp0_data(rsp0_data), .rsp0_flags(rsp0_flags),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
    .rsp1_data(rsp1_data), .rsp1_flags(rsp1_flags),
    .alu_R2(alu_R2), .alu_R3(alu_R3), .alu_op(alu_op),
    .alu_R0(alu_R0), .alu_overflow(alu_overflow),
    .alu_zero(alu_zero), .alu_carry(alu_carry)
  );

  // ---------------------------------------------------------------------------
  // ALU behaviour: returns {overflow, zero, carry, result}
  // ---------------------------------------------------------------------------
  function automatic logic [W-1:0] alu_ref(input logic [N-1:0] a, input logic [N-1:0] b,
                                           input logic [2:0] op);
    logic [N:0]   s;
    logic [N-1:0] r;
    logic         c, v;
    s = '0; r = '0; c = 1'b0; v = 1'b0;
    case (op)
      3'b000: r = a;
      3'b001: r = ~a;
      3'b010: begin
        s = {1'b0, a} + {1'b0, b};
        r = s[N-1:0];
        c = s[N];
        v = (a[N-1] == b[N-1]) && (r[N-1] != a[N-1]);
      end
      3'b011: r = ~(a | b);
      3'b100: begin
        s = {1'b0, a} + {1'b0, ~b} + {{N{1'b0}}, 1'b1};
        r = s[N-1:0];
        c = s[N];
        v = (a[N-1] != b[N-1]) && (r[N-1] != a[N-1]);
      end
      3'b101: r = ~(a & b);
      3'b110: r = ($signed(a) < $signed(b)) ? {{(N-1){1'b0}}, 1'b1} : '0;
      default: r = a ^ b;
    endcase
    return {v, (r == '0), c, r};
  endfunction

  // Datapath stand-in: operands registered at edge t feed one pipeline
  // register, so the result is on alu_R0 for sampling at edge t+2 (LAT=2).
  logic [W-1:0] dp_q = '0;
  always @(posedge clk) dp_q <= alu_ref(alu_R2, alu_R3, alu_op);
  assign alu_R0       = dp_q[N-1:0];
  assign alu_carry    = dp_q[N];
  assign alu_zero     = dp_q[N+1];
  assign alu_overflow = dp_q[N+2];

  // ---------------------------------------------------------------------------
  // Scoreboard state
  // ---------------------------------------------------------------------------
  logic [W-1:0] exp_q [2][$];
  int           avail_q [2][$];
  int           outstanding [2];
  int           dut_out [2];
  logic         ptr_m;
  logic [N-1:0] last_a, last_b;
  logic [2:0]   last_op;
  int           cyc = 0;
  int           n_cmp = 0;
  int           n_err = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Monitor: samples on the falling edge, between input updates and the next
  // active edge. Predicts what the coming rising edge will do.
  // ---------------------------------------------------------------------------
  always @(negedge clk) begin
    logic [1:0]   vv, rr, rv, ac, elig, exp_rdy;
    logic         gv, gid, ev;
    logic [N-1:0] ga, gb;
    logic [2:0]   gop;
    logic [W-1:0] got;
    if (!rst_n) begin
      check("reset_req_ready", 64'({req1_ready, req0_ready}), 64'd0);
      check("reset_rsp_valid", 64'({rsp1_valid, rsp0_valid}), 64'd0);
      check("reset_rsp0_head", 64'({rsp0_flags, rsp0_data}), 64'd0);
      check("reset_rsp1_head", 64'({rsp1_flags, rsp1_data}), 64'd0);
      check("reset_alu_regs", 64'({alu_R3, alu_R2}), 64'd0);
      check("reset_alu_op", 64'(alu_op), 64'd0);
      for (int k = 0; k < 2; k++) begin
        exp_q[k].delete();
        avail_q[k].delete();
        outstanding[k] = 0;
        dut_out[k] = 0;
      end
      ptr_m = 1'b0;
      last_a = '0; last_b = '0; last_op = '0;
    end else begin
      vv = {req1_valid, req0_valid};
      rr = {rsp1_ready, rsp0_ready};
      rv = {rsp1_valid, rsp0_valid};
      ac = {req1_ready, req0_ready};
      for (int k = 0; k < 2; k++) elig[k] = vv[k] && (outstanding[k] < DEPTH);
      gv = elig[0] || elig[1];
      gid = (elig[0] && elig[1]) ? ptr_m : elig[1];
      exp_rdy = gv ? (gid ? 2'b10 : 2'b01) : 2'b00;
      check("req_ready", 64'(ac), 64'(exp_rdy));
      check("alu_operands", 64'({alu_R3, alu_R2}), 64'({last_b, last_a}));
      check("alu_op", 64'(alu_op), 64'(last_op));

      // Responses
      for (int k = 0; k < 2; k++) begin
        ev = 1'b0;
        if (exp_q[k].size() != 0) ev = (avail_q[k][0] <= cyc);
        check($sformatf("rsp%0d_valid", k), 64'(rv[k]), 64'(ev));
        if (rv[k] && rr[k]) begin
          dut_out[k]--;
          if (ev) begin
            got = (k == 0) ? {rsp0_flags, rsp0_data} : {rsp1_flags, rsp1_data};
            check($sformatf("rsp%0d_payload", k), 64'(got), 64'(exp_q[k].pop_front()));
            void'(avail_q[k].pop_front());
            outstanding[k]--;
          end
        end
      end

      // Issue predicted by the model
      if (gv) begin
        ga  = gid ? req1_a  : req0_a;
        gb  = gid ? req1_b  : req0_b;
        gop = gid ? req1_op : req0_op;
        exp_q[gid].push_back(alu_ref(ga, gb, gop));
        avail_q[gid].push_back(cyc + 1 + LAT);
        outstanding[gid]++;
        ptr_m = ~gid;
        last_a = ga; last_b = gb; last_op = gop;
      end

      // Accepted-but-unconsumed count seen at the DUT ports must stay within
      // the FIFO depth, otherwise a result would return into a full FIFO.
      for (int k = 0; k < 2; k++) begin
        if (ac[k]) begin
          dut_out[k]++;
          check($sformatf("credit_bound%0d", k), 64'(dut_out[k] <= DEPTH), 64'd1);
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  task automatic drive(input logic v0, input logic v1, input logic r0, input logic r1);
    @(posedge clk);
    #1;
    req0_valid = v0; req1_valid = v1;
    rsp0_ready = r0; rsp1_ready = r1;
    req0_a = $urandom; req0_b = $urandom; req0_op = 3'($urandom_range(0, 7));
    req1_a = $urandom; req1_b = $urandom; req1_op = 3'($urandom_range(0, 7));
  endtask

  task automatic directed(input int k, input logic [N-1:0] a, input logic [N-1:0] b,
                          input logic [2:0] op);
    drive(k == 0, k == 1, 1'b1, 1'b1);
    if (k == 0) begin req0_a = a; req0_b = b; req0_op = op; end
    else        begin req1_a = a; req1_b = b; req1_op = op; end
    drive(1'b0, 1'b0, 1'b1, 1'b1);
  endtask

  task automatic run(input int cycles, input logic v0, input logic v1,
                     input logic r0, input logic r1);
    for (int i = 0; i < cycles; i++) drive(v0, v1, r0, r1);
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    req0_valid = 1'b0; req1_valid = 1'b0; rsp0_ready = 1'b0; rsp1_ready = 1'b0;
    req0_a = '0; req0_b = '0; req0_op = '0;
    req1_a = '0; req1_b = '0; req1_op = '0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // Directed operations, including flag corner cases
    directed(0, 32'd5, 32'd12, 3'b010);
    run(4, 1'b0, 1'b0, 1'b1, 1'b1);
    directed(0, 32'd25, 32'd25, 3'b100);
    directed(1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 3'b010);
    directed(0, 32'hFFFF_FFFF, 32'd5, 3'b110);
    directed(1, 32'h7FFF_FFFF, 32'd1, 3'b010);
    run(5, 1'b0, 1'b0, 1'b1, 1'b1);

    // Both requesters saturating, responses consumed immediately
    run(20, 1'b1, 1'b1, 1'b1, 1'b1);
    run(4, 1'b0, 1'b0, 1'b1, 1'b1);

    // Requester 0 backpressured: its credits run out while req1 keeps going
    run(12, 1'b1, 1'b1, 1'b0, 1'b1);
    run(10, 1'b1, 1'b1, 1'b1, 1'b1);

    // Single requester with immediate consume: issue and pop on one edge
    run(12, 1'b1, 1'b0, 1'b1, 1'b1);
    run(12, 1'b0, 1'b1, 1'b1, 1'b1);

    // Randomised traffic
    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
            $urandom_range(0, 2) != 0, $urandom_range(0, 2) != 0);
    end

    // Reset with operations in flight
    run(3, 1'b1, 1'b1, 1'b0, 1'b0);
    @(posedge clk);
    #2 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    run(10, 1'b1, 1'b1, 1'b1, 1'b1);

    // Drain
    run(10, 1'b0, 1'b0, 1'b1, 1'b1);
    @(negedge clk);
    #1;
    check("drain_q0", 64'(exp_q[0].size()), 64'd0);
    check("drain_q1", 64'(exp_q[1].size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
